fir_accum_out: RTL and testbench

// - Output stage of the 29-tap complex FIR, directly downstream of the 5 complex multipliers.
// - Sums the 5 lane products of each beat and accumulates the beats of one output sample
//   (3 beats cover 15 unique symmetric coefficients).
// - Rounds and saturates the result to 32 bits, then drives PushOut/FI/FQ.

---
 rtl/fir_pkg.sv | 39 +++
 rtl/fir_lane_sum.sv | 23 ++
 rtl/fir_accum_out.sv | 155 +++++++++++++++
 tb/tb_fir_accum_out.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the complex FIR output stage.
// Holds the datapath widths, the accumulator type, the two FSM state codes and the
// round/saturate helper that maps an accumulated sum onto a 32-bit output sample.
package fir_pkg;

    localparam int unsigned NLANES  = 5;   // complex multiplier lanes per beat
    localparam int unsigned PW      = 54;  // signed product width per lane
    localparam int unsigned ACCW    = 60;  // signed accumulator width
    localparam int unsigned OUTW    = 32;  // output sample width
    localparam int unsigned SHIFT   = 22;  // fixed-point alignment shift
    localparam int unsigned MAXBEAT = 3;   // maximum beats per output sample
    localparam int unsigned CNTW    = 2;   // beat counter width, holds 0..MAXBEAT

    typedef logic signed [ACCW-1:0] acc_t;
    typedef logic signed [OUTW-1:0] out_t;

    // FSM state codes
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    localparam acc_t ROUND_BIAS = acc_t'(1) << (SHIFT - 1);
    localparam acc_t OUT_MAX    = acc_t'({1'b0, {(OUTW - 1){1'b1}}});
    localparam acc_t OUT_MIN    = -OUT_MAX - acc_t'(1);

    // Round half toward +inf, then clamp to the signed 32-bit range.
    // ACCW leaves enough headroom that the bias addition never wraps.
    function automatic out_t sat_round(acc_t a);
        acc_t r;
        r = (a + ROUND_BIAS) >>> SHIFT;
        if (r > OUT_MAX) begin
            sat_round = {1'b0, {(OUTW - 1){1'b1}}};
        end else if (r < OUT_MIN) begin
            sat_round = {1'b1, {(OUTW - 1){1'b0}}};
        end else begin
            sat_round = r[OUTW-1:0];
        end
    endfunction

endpackage

// File: rtl/fir_lane_sum.sv
// Combinational sum of the NLANES signed lane products of one beat.
// Ports:
//   prod_i  packed signed lane products, lane k = prod_i[k*PW +: PW]
//   sum_o   signed sum, sign-extended to the accumulator width
module fir_lane_sum
    import fir_pkg::*;
(
    input  logic [NLANES*PW-1:0] prod_i,
    output logic [ACCW-1:0]      sum_o
);

    acc_t sum;

    always_comb begin
        sum = '0;
        for (int k = 0; k < int'(NLANES); k++) begin
            sum = sum + acc_t'($signed(prod_i[k*PW +: PW]));
        end
    end

    assign sum_o = sum;

endmodule

// File: rtl/fir_accum_out.sv
// Output stage of the 29-tap complex FIR.
// Sums the lane products of each beat (S1), accumulates the beats of one output sample
// and checks the beat framing (S2), then rounds/saturates into FI/FQ (S3).
// Ports:
//   Clk, Reset          rising-edge clock, asynchronous active-low reset
//   ProdValid/First/Last beat strobe and sample framing flags
//   ProdI, ProdQ        packed signed lane products (real, imaginary)
//   PushOut             one-cycle strobe, FI/FQ hold a new output
//   FI, FQ              rounded/saturated signed outputs, held between pushes
//   ErrSeq              one-cycle strobe on a framing violation
module fir_accum_out
    import fir_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 ProdValid,
    input  logic                 ProdFirst,
    input  logic                 ProdLast,
    input  logic [NLANES*PW-1:0] ProdI,
    input  logic [NLANES*PW-1:0] ProdQ,
    output logic                 PushOut,
    output logic [OUTW-1:0]      FI,
    output logic [OUTW-1:0]      FQ,
    output logic                 ErrSeq
);

    logic [ACCW-1:0] lane_i, lane_q;

    fir_lane_sum u_sum_i (.prod_i(ProdI), .sum_o(lane_i));
    fir_lane_sum u_sum_q (.prod_i(ProdQ), .sum_o(lane_q));

    // S1: registered beat sum
    logic s1_valid_q, s1_first_q, s1_last_q;
    acc_t s1_i_q, s1_q_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
        end else begin
            s1_valid_q <= ProdValid;
            s1_first_q <= ProdFirst;
            s1_last_q  <= ProdLast;
            s1_i_q     <= lane_i;
            s1_q_q     <= lane_q;
        end
    end

    // S2: framing FSM and accumulator
    logic [0:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    acc_t            acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    acc_t            tot_i_q, tot_i_d, tot_q_q, tot_q_d;
    acc_t            sum_i, sum_q;
    logic            emit_q, emit_d, err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        tot_i_d = tot_i_q;
        tot_q_d = tot_q_q;
        emit_d  = 1'b0;
        err_d   = 1'b0;
        sum_i   = acc_i_q + s1_i_q;
        sum_q   = acc_q_q + s1_q_q;
        cnt_inc = cnt_q + 1'b1;
        if (s1_valid_q) begin
            if (state_q == ACC && !s1_first_q) begin
                if (s1_last_q) begin
                    emit_d  = 1'b1;
                    tot_i_d = sum_i;
                    tot_q_d = sum_q;
                    state_d = IDLE;
                end else if (cnt_inc == CNTW'(MAXBEAT)) begin
                    // Sample would run past MAXBEAT beats: discard it
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    acc_i_d = sum_i;
                    acc_q_d = sum_q;
                    cnt_d   = cnt_inc;
                end
            end else begin
                // IDLE, or a First beat arriving mid-sample which restarts the sample
                err_d = (state_q == ACC) || !s1_first_q;
                if (!s1_first_q) begin
                    state_d = IDLE;
                end else begin
                    acc_i_d = s1_i_q;
                    acc_q_d = s1_q_q;
                    if (s1_last_q) begin
                        emit_d  = 1'b1;
                        tot_i_d = s1_i_q;
                        tot_q_d = s1_q_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = CNTW'(1);
                        state_d = ACC;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            tot_i_q <= '0;
            tot_q_q <= '0;
            emit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            tot_i_q <= tot_i_d;
            tot_q_q <= tot_q_d;
            emit_q  <= emit_d;
            err_q   <= err_d;
        end
    end

    // S3: round/saturate and output register
    logic            push_q;
    logic [OUTW-1:0] fi_q, fq_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            push_q <= 1'b0;
            fi_q   <= '0;
            fq_q   <= '0;
        end else begin
            push_q <= emit_q;
            if (emit_q) begin
                fi_q <= sat_round(tot_i_q);
                fq_q <= sat_round(tot_q_q);
            end
        end
    end

    assign PushOut = push_q;
    assign FI      = fi_q;
    assign FQ      = fq_q;
    assign ErrSeq  = err_q;

endmodule

// File: tb/tb_fir_accum_out.sv
module tb_fir_accum_out;

    localparam int NL = 5;
    localparam int W  = 54;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            ProdValid, ProdFirst, ProdLast;
    logic [NL*W-1:0] ProdI, ProdQ;
    logic            PushOut, ErrSeq;
    logic [31:0]     FI, FQ;

    fir_accum_out dut (
        .Clk(Clk), .Reset(Reset), .ProdValid(ProdValid), .ProdFirst(ProdFirst),
        .ProdLast(ProdLast), .ProdI(ProdI), .ProdQ(ProdQ), .PushOut(PushOut),
        .FI(FI), .FQ(FQ), .ErrSeq(ErrSeq)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: one output sample is the list of its beat sums.
    typedef struct {
        longint fi;
        longint fq;
        int     cyc;
    } exp_t;

    exp_t   exp_q[$];
    longint cur_i[$], cur_q[$];
    longint lane_i[NL], lane_q[NL];
    int     m_err = 0, m_push = 0;

    function automatic longint out_val(longint x);
        longint r;
        r = (x + 64'sd2097152) >>> 22;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
        return r;
    endfunction

    task automatic model_beat(input bit first, input bit last);
        longint si = 0, sq = 0, ti = 0, tq = 0;
        exp_t e;
        for (int k = 0; k < NL; k++) begin
            si += lane_i[k];
            sq += lane_q[k];
        end
        if (first) begin
            if (cur_i.size() != 0) m_err++;
            cur_i.delete();
            cur_q.delete();
            cur_i.push_back(si);
            cur_q.push_back(sq);
        end else if (cur_i.size() == 0) begin
            m_err++;
        end else begin
            cur_i.push_back(si);
            cur_q.push_back(sq);
        end
        if (cur_i.size() != 0) begin
            if (last) begin
                foreach (cur_i[j]) begin
                    ti += cur_i[j];
                    tq += cur_q[j];
                end
                e.fi  = out_val(ti);
                e.fq  = out_val(tq);
                e.cyc = cyc + 3;
                exp_q.push_back(e);
                m_push++;
                cur_i.delete();
                cur_q.delete();
            end else if (cur_i.size() == 3) begin
                m_err++;
                cur_i.delete();
                cur_q.delete();
            end
        end
    endtask

    // Monitor
    int     push_seen = 0, err_seen = 0;
    longint last_fi = 0, last_fq = 0;
    exp_t   mon_e;

    always @(negedge Clk) begin
        if (Reset && ErrSeq) err_seen++;
        if (Reset && PushOut) begin
            push_seen++;
            last_fi = longint'($signed(FI));
            last_fq = longint'($signed(FQ));
            if (exp_q.size() == 0) begin
                check_eq("push_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("push_cycle", cyc, mon_e.cyc);
                check_eq("fi", last_fi, mon_e.fi);
                check_eq("fq", last_fq, mon_e.fq);
            end
        end
    end

    function automatic longint rand_prod();
        longint v;
        v = {$urandom(), $urandom()};
        return v >>> (10 + $urandom_range(0, 24));
    endfunction

    task automatic set_lanes(input longint vi, input longint vq, input bit all);
        for (int k = 0; k < NL; k++) begin
            lane_i[k] = (all || k == 0) ? vi : 64'sd0;
            lane_q[k] = (all || k == 0) ? vq : 64'sd0;
        end
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < NL; k++) begin
            lane_i[k] = rand_prod();
            lane_q[k] = rand_prod();
        end
    endtask

    task automatic beat(input bit first, input bit last);
        @(posedge Clk);
        #1;
        ProdValid = 1'b1;
        ProdFirst = first;
        ProdLast  = last;
        for (int k = 0; k < NL; k++) begin
            ProdI[k*W +: W] = lane_i[k][W-1:0];
            ProdQ[k*W +: W] = lane_q[k][W-1:0];
        end
        model_beat(first, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
            ProdValid = 1'b0;
            ProdFirst = $urandom_range(0, 1);
            ProdLast  = $urandom_range(0, 1);
            ProdI     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                         $urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic checkpoint(input string tag);
        idle(6);
        check_eq({tag, "_err"}, err_seen, m_err);
        check_eq({tag, "_pushes"}, push_seen, m_push);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
    endtask

    int p0, e0;

    initial begin
        Reset     = 1'b0;
        ProdValid = 1'b0;
        ProdFirst = 1'b0;
        ProdLast  = 1'b0;
        ProdI     = '0;
        ProdQ     = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_push", PushOut, 0);
        check_eq("rst_fi", FI, 0);
        check_eq("rst_fq", FQ, 0);
        check_eq("rst_err", ErrSeq, 0);
        Reset = 1'b1;
        idle(2);

        // Single beat rounding of +1.5 / -1.5
        set_lanes(64'sd3 <<< 21, -(64'sd3 <<< 21), 1'b0);
        beat(1, 1);
        checkpoint("single");
        check_eq("single_fi", last_fi, 2);
        check_eq("single_fq", last_fq, -1);

        // Three beats, all lanes 1<<22
        set_lanes(64'sd1 <<< 22, 64'sd1 <<< 22, 1'b1);
        p0 = push_seen;
        beat(1, 0); beat(0, 0); beat(0, 1);
        checkpoint("three");
        check_eq("three_fi", last_fi, 15);
        check_eq("three_fq", last_fq, 15);
        check_eq("three_npush", push_seen - p0, 1);

        // Saturation, positive and negative
        set_lanes((64'sd1 <<< 53) - 1, 64'sd0, 1'b1);
        beat(1, 0); beat(0, 0); beat(0, 1);
        checkpoint("satpos");
        check_eq("satpos_fi", last_fi, 64'sd2147483647);
        set_lanes(-(64'sd1 <<< 53), 64'sd0, 1'b1);
        beat(1, 0); beat(0, 0); beat(0, 1);
        checkpoint("satneg");
        check_eq("satneg_fi", last_fi, -64'sd2147483648);

        // Reset mid-sample discards the partial sum
        set_lanes(64'sd5 <<< 22, 64'sd7 <<< 22, 1'b0);
        p0 = push_seen;
        beat(1, 0);
        idle(1);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cur_i.delete();
        cur_q.delete();
        #2;
        check_eq("midrst_fi", FI, 0);
        check_eq("midrst_fq", FQ, 0);
        check_eq("midrst_push", PushOut, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        checkpoint("midrst");
        check_eq("midrst_npush", push_seen - p0, 0);

        // Framing: beat without First while idle
        e0 = err_seen; p0 = push_seen;
        rand_lanes();
        beat(0, 1);
        checkpoint("nofirst");
        check_eq("nofirst_nerr", err_seen - e0, 1);
        check_eq("nofirst_npush", push_seen - p0, 0);

        // Framing: First while accumulating restarts the sample
        e0 = err_seen; p0 = push_seen;
        set_lanes(64'sd9 <<< 22, 64'sd9 <<< 22, 1'b0);
        beat(1, 0);
        set_lanes(64'sd2 <<< 22, -(64'sd3 <<< 22), 1'b0);
        beat(1, 0);
        beat(0, 1);
        checkpoint("restart");
        check_eq("restart_nerr", err_seen - e0, 1);
        check_eq("restart_fi", last_fi, 4);
        check_eq("restart_fq", last_fq, -6);

        // Framing: sample running past three beats
        e0 = err_seen; p0 = push_seen;
        rand_lanes();
        beat(1, 0); beat(0, 0); beat(0, 0);
        checkpoint("overlong");
        check_eq("overlong_nerr", err_seen - e0, 1);
        check_eq("overlong_npush", push_seen - p0, 0);

        // Streaming: 20 back-to-back 3-beat samples
        p0 = push_seen;
        for (int s = 0; s < 20; s++) begin
            rand_lanes(); beat(1, 0);
            rand_lanes(); beat(0, 0);
            rand_lanes(); beat(0, 1);
        end
        checkpoint("stream");
        check_eq("stream_npush", push_seen - p0, 20);

        // Random framing soak
        for (int i = 0; i < 300; i++) begin
            rand_lanes();
            if ($urandom_range(0, 9) < 2) begin
                idle(1);
            end else begin
                beat($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            end
        end
        checkpoint("soak");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
